// File: rtl/traffic_phase_scheduler.sv
// Four-way traffic phase scheduler: max-queue selection with a starvation override,
// green/yellow/all-red phase timing and paced drain pulses to the served direction's counter.
module traffic_phase_scheduler #(
    parameter int unsigned CW         = 4,
    parameter int unsigned TW         = 6,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MAX_GREEN  = 20,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 1,
    parameter int unsigned STARVE_LIM = 3,
    parameter int unsigned DRAIN_DIV  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [4*CW-1:0] cnt,
    output logic [3:0]      green,
    output logic [3:0]      yellow,
    output logic [3:0]      red,
    output logic [3:0]      drain,
    output logic [1:0]      cur_dir,
    output logic [1:0]      phase
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam int unsigned DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    typedef enum logic [1:0] {
        StAllRed  = 2'b00,
        StGreen   = 2'b01,
        StYellow  = 2'b10,
        StInvalid = 2'b11
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   elapsed_q, elapsed_d;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      rr_q, rr_d;
    logic [SW-1:0]   starve_q [4];
    logic [SW-1:0]   starve_d [4];
    logic [3:0]      green_q, green_d;
    logic [3:0]      yellow_q, yellow_d;
    logic [3:0]      red_q, red_d;
    logic [3:0]      drain_q, drain_d;

    logic [CW-1:0]   cnt_dir [4];
    logic            any_cnt;
    logic            win_starved;
    logic [1:0]      starve_dir;
    logic [1:0]      max_dir;
    logic [1:0]      win_dir;
    logic [1:0]      scan_dir;
    logic [CW-1:0]   best_cnt;
    logic [TW-1:0]   elapsed_inc;
    logic [DW-1:0]   div_inc;
    logic            cur_empty;
    logic            green_done;

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            cnt_dir[d] = cnt[d*CW +: CW];
        end
    end

    assign any_cnt = |cnt;

    // Both candidates are found in one scan starting at the round-robin pointer, so the first
    // hit in scan order wins starvation ties and max-count ties alike.
    always_comb begin
        win_starved = 1'b0;
        starve_dir  = '0;
        max_dir     = '0;
        best_cnt    = '0;
        scan_dir    = '0;
        for (int i = 0; i < 4; i++) begin
            scan_dir = rr_q + 2'(i);
            if (!win_starved && (starve_q[scan_dir] >= SW'(STARVE_LIM)) &&
                (cnt_dir[scan_dir] != '0)) begin
                win_starved = 1'b1;
                starve_dir  = scan_dir;
            end
            if (cnt_dir[scan_dir] > best_cnt) begin
                best_cnt = cnt_dir[scan_dir];
                max_dir  = scan_dir;
            end
        end
        win_dir = win_starved ? starve_dir : max_dir;
    end

    assign elapsed_inc = elapsed_q + 1'b1;
    assign div_inc     = ((32'(div_q) + 1) == DRAIN_DIV) ? '0 : div_q + 1'b1;
    assign cur_empty   = (cnt_dir[dir_q] == '0);
    assign green_done  = ((elapsed_inc >= TW'(MIN_GREEN)) && cur_empty) ||
                         (elapsed_inc == TW'(MAX_GREEN));

    always_comb begin
        phase_d   = phase_q;
        timer_d   = timer_q;
        elapsed_d = elapsed_q;
        div_d     = div_q;
        dir_d     = dir_q;
        rr_d      = rr_q;
        starve_d  = starve_q;
        drain_d   = '0;

        if (phase_q == StInvalid) begin
            phase_d = StAllRed;
            timer_d = TW'(ALLRED_T);
        end else if (en) begin
            unique case (phase_q)
                StAllRed: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end else if (any_cnt) begin
                        phase_d   = StGreen;
                        dir_d     = win_dir;
                        rr_d      = win_dir + 2'd1;
                        elapsed_d = '0;
                        div_d     = '0;
                        drain_d[win_dir] = (DRAIN_DIV == 1) && (cnt_dir[win_dir] != '0);
                        for (int d = 0; d < 4; d++) begin
                            if (2'(d) == win_dir) begin
                                starve_d[d] = '0;
                            end else if (cnt_dir[d] != '0) begin
                                starve_d[d] = (starve_q[d] >= SW'(STARVE_LIM)) ?
                                              SW'(STARVE_LIM) : starve_q[d] + 1'b1;
                            end else begin
                                starve_d[d] = '0;
                            end
                        end
                    end
                end
                StGreen: begin
                    if (green_done) begin
                        phase_d = StYellow;
                        timer_d = TW'(YELLOW_T - 1);
                    end else begin
                        elapsed_d = elapsed_inc;
                        div_d     = div_inc;
                        // Registered pulse lands in the green cycle on which the divider wraps.
                        drain_d[dir_q] = (32'(div_inc) == (DRAIN_DIV - 1)) && !cur_empty;
                    end
                end
                StYellow: begin
                    if (timer_q == '0) begin
                        phase_d = StAllRed;
                        timer_d = TW'(ALLRED_T - 1);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        green_d  = '0;
        yellow_d = '0;
        if (phase_d == StGreen) begin
            green_d[dir_d] = 1'b1;
        end
        if (phase_d == StYellow) begin
            yellow_d[dir_d] = 1'b1;
        end
        red_d = ~green_d & ~yellow_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= StAllRed;
            timer_q   <= TW'(ALLRED_T);
            elapsed_q <= '0;
            div_q     <= '0;
            dir_q     <= '0;
            rr_q      <= '0;
            for (int d = 0; d < 4; d++) begin
                starve_q[d] <= '0;
            end
            green_q   <= '0;
            yellow_q  <= '0;
            red_q     <= 4'b1111;
            drain_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            elapsed_q <= elapsed_d;
            div_q     <= div_d;
            dir_q     <= dir_d;
            rr_q      <= rr_d;
            starve_q  <= starve_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            red_q     <= red_d;
            drain_q   <= drain_d;
        end
    end

    assign green   = green_q;
    assign yellow  = yellow_q;
    assign red     = red_q;
    assign drain   = drain_q;
    assign cur_dir = dir_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a per-direction queue counter model that
// decrements on drain pulses (optionally held full to model constant arrivals).
module tb_traffic_phase_scheduler;

    localparam int unsigned CW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [4*CW-1:0] cnt;
    logic [3:0]      green;
    logic [3:0]      yellow;
    logic [3:0]      red;
    logic [3:0]      drain;
    logic [1:0]      cur_dir;
    logic [1:0]      phase;

    logic [CW-1:0]   cnt_m [4];
    logic [3:0]      refill;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .CW        (CW),
        .TW        (6),
        .MIN_GREEN (4),
        .MAX_GREEN (20),
        .YELLOW_T  (3),
        .ALLRED_T  (1),
        .STARVE_LIM(3),
        .DRAIN_DIV (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .cnt    (cnt),
        .green  (green),
        .yellow (yellow),
        .red    (red),
        .drain  (drain),
        .cur_dir(cur_dir),
        .phase  (phase)
    );

    // One clock; the counter model applies the drain seen during the cycle that just ended.
    task automatic tick();
        logic [3:0] d_s;
        d_s = drain;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (d_s[d] && !refill[d] && cnt_m[d] != '0) cnt_m[d] = cnt_m[d] - 1'b1;
        end
        cnt = {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]};
    endtask

    task automatic do_reset(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                            input logic [CW-1:0] c2, input logic [CW-1:0] c3,
                            input logic [3:0] rf);
        en       = 1'b1;
        cnt_m[0] = c0;
        cnt_m[1] = c1;
        cnt_m[2] = c2;
        cnt_m[3] = c3;
        refill   = rf;
        cnt      = {c3, c2, c1, c0};
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance to the start of the next green phase (leaving any current one first).
    task automatic wait_green(output logic [1:0] dir, output logic [3:0] g, output bit ok);
        int n;
        n = 0;
        while (phase == 2'b01 && n < 100) begin
            tick();
            n++;
        end
        while (phase != 2'b01 && n < 100) begin
            tick();
            n++;
        end
        ok  = (phase == 2'b01);
        dir = cur_dir;
        g   = green;
    endtask

    task automatic test_reset();
        do_reset(0, 0, 0, 0, 4'b0000);
        checks++;
        if ({red, green, yellow, drain, phase, cur_dir} !== {4'b1111, 4'b0, 4'b0, 4'b0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got red=%b green=%b yellow=%b drain=%b phase=%b dir=%0d required red=1111 green=0000 yellow=0000 drain=0000 phase=00 dir=0",
                     red, green, yellow, drain, phase, cur_dir);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if ({phase, red, drain} !== {2'b00, 4'b1111, 4'b0000}) begin
                errors++;
                $display("FAIL idle_allred n=%0d: got phase=%b red=%b drain=%b required phase=00 red=1111 drain=0000",
                         n, phase, red, drain);
            end
        end
    endtask

    task automatic test_single_drain();
        logic [1:0] exp_phase;
        logic [3:0] exp_drain;
        logic [3:0] exp_green;
        logic [3:0] exp_yellow;
        int         pulses;
        pulses = 0;
        do_reset(5, 0, 0, 0, 4'b0000);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (drain[0]) pulses++;
            exp_phase  = (n == 1) ? 2'b00 : (n <= 12) ? 2'b01 : (n <= 15) ? 2'b10 : 2'b00;
            exp_drain  = (n >= 3 && n <= 11 && (n % 2) == 1) ? 4'b0001 : 4'b0000;
            exp_green  = (exp_phase == 2'b01) ? 4'b0001 : 4'b0000;
            exp_yellow = (exp_phase == 2'b10) ? 4'b0001 : 4'b0000;
            checks++;
            if ({phase, green, yellow, drain} !== {exp_phase, exp_green, exp_yellow, exp_drain}) begin
                errors++;
                $display("FAIL single_drain n=%0d: got phase=%b green=%b yellow=%b drain=%b required phase=%b green=%b yellow=%b drain=%b",
                         n, phase, green, yellow, drain, exp_phase, exp_green, exp_yellow, exp_drain);
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL single_drain_pulses: got %0d required 5", pulses);
        end
    endtask

    task automatic test_tie_rotation();
        logic [1:0] dir;
        logic [3:0] g;
        bit         ok;
        logic [3:0] exp_g;
        do_reset(4, 4, 4, 4, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            wait_green(dir, g, ok);
            exp_g = 4'b0001 << i;
            checks++;
            if (!ok || dir !== 2'(i) || g !== exp_g) begin
                errors++;
                $display("FAIL tie_order #%0d: got ok=%0d dir=%0d green=%b required ok=1 dir=%0d green=%b",
                         i, ok, dir, g, i, exp_g);
            end
        end
    endtask

    task automatic test_starvation();
        logic [1:0] dir;
        logic [3:0] g;
        bit         ok;
        int         len;
        logic [1:0] exp_dir [5];
        exp_dir[0] = 2'd0;
        exp_dir[1] = 2'd0;
        exp_dir[2] = 2'd0;
        exp_dir[3] = 2'd1;
        exp_dir[4] = 2'd2;
        do_reset(15, 1, 1, 0, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_green(dir, g, ok);
            checks++;
            if (!ok || dir !== exp_dir[i]) begin
                errors++;
                $display("FAIL starve_order #%0d: got ok=%0d dir=%0d required ok=1 dir=%0d",
                         i, ok, dir, exp_dir[i]);
            end
            if (i == 0) begin
                len = 1;
                while (phase == 2'b01 && len < 40) begin
                    tick();
                    if (phase == 2'b01) len++;
                end
                checks++;
                if (len != 20) begin
                    errors++;
                    $display("FAIL max_green_len: got %0d required 20", len);
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        int rem;
        do_reset(9, 0, 0, 0, 4'b0001);
        tick();
        tick();
        checks++;
        if (phase !== 2'b01) begin
            errors++;
            $display("FAIL freeze_enter: got phase=%b required 01", phase);
        end
        tick();
        checks++;
        if (drain !== 4'b0001) begin
            errors++;
            $display("FAIL freeze_pre_drain: got drain=%b required 0001", drain);
        end
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({phase, green, yellow, red, drain} !== {2'b01, 4'b0001, 4'b0000, 4'b1110, 4'b0000}) begin
                errors++;
                $display("FAIL freeze_hold i=%0d: got phase=%b green=%b yellow=%b red=%b drain=%b required phase=01 green=0001 yellow=0000 red=1110 drain=0000",
                         i, phase, green, yellow, red, drain);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (drain !== 4'b0001) begin
            errors++;
            $display("FAIL freeze_resume_drain: got drain=%b required 0001", drain);
        end
        rem = 1;
        while (phase == 2'b01 && rem < 40) begin
            tick();
            if (phase == 2'b01) rem++;
        end
        checks++;
        if (rem != 17) begin
            errors++;
            $display("FAIL freeze_remaining_green: got %0d required 17", rem);
        end
    endtask

    task automatic test_reset_mid_yellow();
        logic [1:0] dir;
        logic [3:0] g;
        bit         ok;
        int         n;
        do_reset(15, 1, 1, 0, 4'b0001);
        for (int i = 0; i < 3; i++) wait_green(dir, g, ok);
        n = 0;
        while (phase != 2'b10 && n < 60) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (yellow !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset_yellow: got yellow=%b required 0001", yellow);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({red, green, yellow, drain, phase} !== {4'b1111, 4'b0, 4'b0, 4'b0, 2'b00}) begin
            errors++;
            $display("FAIL async_reset: got red=%b green=%b yellow=%b drain=%b phase=%b required red=1111 green=0000 yellow=0000 drain=0000 phase=00",
                     red, green, yellow, drain, phase);
        end
        do_reset(15, 1, 1, 0, 4'b0001);
        wait_green(dir, g, ok);
        checks++;
        if (!ok || dir !== 2'd0) begin
            errors++;
            $display("FAIL starve_cleared: got ok=%0d dir=%0d required ok=1 dir=0", ok, dir);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        cnt    = '0;
        refill = '0;
        for (int d = 0; d < 4; d++) cnt_m[d] = '0;
        test_reset();
        test_single_drain();
        test_tie_rotation();
        test_starvation();
        test_enable_freeze();
        test_reset_mid_yellow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
